video_img_overlay: RTL and testbench

//  AXI4-Stream video pattern generator. It draws a BRAM-backed IMGW x IMGH image at a runtime position
//  on a solid background of runtime-trimmed resolution. An internal prefetch FIFO with credit-based BRAM

---
 rtl/video_img_overlay.sv | 202 ++++++++++++++++++++
 tb/tb_video_img_overlay.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/video_img_overlay.sv
// rtl/video_img_overlay.sv - AXI4-Stream generator: BRAM image drawn over a solid background
// Build macro VIDEO_IMG_BORDER_EN paints the 1-pixel ring around the image with ~BG_COLOR.
module video_img_overlay #(
  parameter int               DATAW      = 24,
  parameter int               SCRW       = 1920,
  parameter int               SCRH       = 1080,
  parameter int               IMGW       = 300,
  parameter int               IMGH       = 370,
  parameter int               ADDRW      = 17,
  parameter int               BRAM_LAT   = 2,
  parameter int               FIFO_DEPTH = 16,
  parameter logic [DATAW-1:0] BG_COLOR   = 24'h010101
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic               en,
  input  logic [12:0]        img_x,
  input  logic [12:0]        img_y,
  input  logic [12:0]        subw,
  input  logic [12:0]        addw,
  input  logic [12:0]        subh,
  input  logic [12:0]        addh,
  output logic [DATAW-1:0]   m_axis_tdata,
  output logic               m_axis_tvalid,
  input  logic               m_axis_tready,
  output logic               m_axis_tuser,
  output logic               m_axis_tlast,
  output logic [DATAW/8-1:0] m_axis_tkeep,
  output logic [DATAW/8-1:0] m_axis_tstrb,
  output logic               m_axis_tid,
  output logic               m_axis_tdest,
  output logic               bram_en_o,
  output logic [ADDRW-1:0]   bram_addr_o,
  input  logic [DATAW-1:0]   bram_data_i,
  output logic [15:0]        frame_cnt,
  output logic               underflow,
  output logic               cfg_err
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [ADDRW:0]  TOTAL   = (ADDRW+1)'(IMGW * IMGH);
  localparam logic [CW-1:0]   DEPTH_C = CW'(FIFO_DEPTH);
  localparam logic [13:0]     IMGW14  = 14'(IMGW);
  localparam logic [13:0]     IMGH14  = 14'(IMGH);

  typedef enum logic [1:0] {IDLE, PREFETCH, ACTIVE} state_t;
  state_t state;

  logic [12:0]         w, h, ix, iy, x, y;
  logic                win_ok, loaded_all, eof;
  logic [ADDRW:0]      addr;
  logic [BRAM_LAT-1:0] vld_sr;
  logic [CW-1:0]       count, in_flight;
  logic [PW-1:0]       wr_ptr, rd_ptr;
  logic [DATAW-1:0]    mem [FIFO_DEPTH];

  assign m_axis_tkeep = '1;
  assign m_axis_tstrb = '1;
  assign m_axis_tid   = 1'b0;
  assign m_axis_tdest = 1'b0;

  // Geometry for the frame about to start; a zero dimension degenerates to one pixel
  logic [12:0] w_raw, h_raw, w_new, h_new;
  logic        win_ok_new;
  assign w_raw      = 13'(SCRW) + addw - subw;
  assign h_raw      = 13'(SCRH) + addh - subh;
  assign w_new      = (w_raw == 13'd0) ? 13'd1 : w_raw;
  assign h_new      = (h_raw == 13'd0) ? 13'd1 : h_raw;
  assign win_ok_new = ({1'b0, img_x} + IMGW14 <= {1'b0, w_new}) &&
                      ({1'b0, img_y} + IMGH14 <= {1'b0, h_new});

  logic [13:0] xe, ye, ixe, iye;
  logic        in_win, in_ring;
  assign xe  = {1'b0, x};
  assign ye  = {1'b0, y};
  assign ixe = {1'b0, ix};
  assign iye = {1'b0, iy};
  assign in_win = win_ok && (xe >= ixe) && (xe < ixe + IMGW14) &&
                  (ye >= iye) && (ye < iye + IMGH14);
`ifdef VIDEO_IMG_BORDER_EN
  assign in_ring = win_ok && !in_win && (xe + 14'd1 >= ixe) && (xe <= ixe + IMGW14) &&
                   (ye + 14'd1 >= iye) && (ye <= iye + IMGH14);
`else
  assign in_ring = 1'b0;
`endif

  logic [DATAW-1:0] pix;
  logic issue, push, pop, can_load, load, stall, acc_last, start, prefetch_done;
  assign pix      = in_win ? mem[rd_ptr] : (in_ring ? ~BG_COLOR : BG_COLOR);
  // Credits: words stored plus reads still in the BRAM pipe never exceed the FIFO depth
  assign issue    = (state != IDLE) && win_ok && (addr < TOTAL) && ((count + in_flight) < DEPTH_C);
  assign push     = vld_sr[BRAM_LAT-1];
  assign can_load = (state == ACTIVE) && !loaded_all && (!in_win || count != '0);
  assign load     = can_load && (!m_axis_tvalid || m_axis_tready);
  assign pop      = load && in_win;
  assign stall    = (state == ACTIVE) && !loaded_all && in_win && (count == '0) &&
                    (!m_axis_tvalid || m_axis_tready);
  assign acc_last = (state == ACTIVE) && m_axis_tvalid && m_axis_tready && eof;
  assign start    = en && ((state == IDLE) || acc_last);
  // Look at the post-push count so ACTIVE starts in the same cycle the FIFO fills
  assign prefetch_done = (count + CW'(push) >= DEPTH_C) ||
                         ((addr == TOTAL) && (in_flight == CW'(push))) || !win_ok;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= bram_data_i;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state         <= IDLE;
      w             <= '0;
      h             <= '0;
      ix            <= '0;
      iy            <= '0;
      x             <= '0;
      y             <= '0;
      win_ok        <= 1'b0;
      loaded_all    <= 1'b0;
      eof           <= 1'b0;
      addr          <= '0;
      vld_sr        <= '0;
      count         <= '0;
      in_flight     <= '0;
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      bram_en_o     <= 1'b0;
      bram_addr_o   <= '0;
      m_axis_tdata  <= '0;
      m_axis_tvalid <= 1'b0;
      m_axis_tuser  <= 1'b0;
      m_axis_tlast  <= 1'b0;
      frame_cnt     <= '0;
      underflow     <= 1'b0;
      cfg_err       <= 1'b0;
    end else begin
      bram_en_o <= issue;
      if (issue) bram_addr_o <= addr[ADDRW-1:0];
      vld_sr[0] <= bram_en_o;
      for (int i = 1; i < BRAM_LAT; i++) vld_sr[i] <= vld_sr[i-1];

      if (start) begin
        count     <= '0;
        in_flight <= '0;
        wr_ptr    <= '0;
        rd_ptr    <= '0;
        addr      <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + 1'b1;
        if (pop)  rd_ptr <= rd_ptr + 1'b1;
        count     <= count + CW'(push) - CW'(pop);
        in_flight <= in_flight + CW'(issue) - CW'(push);
        if (issue) addr <= addr + 1'b1;
      end

      if (load) begin
        m_axis_tvalid <= 1'b1;
        m_axis_tdata  <= pix;
        m_axis_tuser  <= (x == 13'd0) && (y == 13'd0);
        m_axis_tlast  <= (x == w - 13'd1);
        eof           <= (x == w - 13'd1) && (y == h - 13'd1);
        if (x == w - 13'd1) begin
          x <= '0;
          if (y == h - 13'd1) loaded_all <= 1'b1;
          else                y <= y + 13'd1;
        end else begin
          x <= x + 13'd1;
        end
      end else if (m_axis_tready) begin
        m_axis_tvalid <= 1'b0;
        m_axis_tuser  <= 1'b0;
        m_axis_tlast  <= 1'b0;
        eof           <= 1'b0;
      end
      if (stall) underflow <= 1'b1;

      case (state)
        IDLE: ;
        PREFETCH: if (prefetch_done) begin
          state      <= ACTIVE;
          x          <= '0;
          y          <= '0;
          loaded_all <= 1'b0;
        end
        ACTIVE: if (acc_last) begin
          frame_cnt <= frame_cnt + 16'd1;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase

      if (start) begin
        state   <= PREFETCH;
        w       <= w_new;
        h       <= h_new;
        ix      <= img_x;
        iy      <= img_y;
        win_ok  <= win_ok_new;
        cfg_err <= !win_ok_new;
      end
    end
  end
endmodule

// File: tb/tb_video_img_overlay.sv
// tb/tb_video_img_overlay.sv - vector table plus pixel scoreboard for video_img_overlay
module tb_video_img_overlay;
  localparam int IW = 4, IH = 3, AW = 4, LAT = 2;
  localparam logic [23:0] BG = 24'h010101;

  logic        clk = 1'b0, rstn = 1'b0, en = 1'b0, tready = 1'b1;
  logic [12:0] img_x = '0, img_y = '0, subw = '0, addw = '0, subh = '0, addh = '0;
  logic [23:0] tdata, bram_data;
  logic        tvalid, tuser, tlast, tid, tdest, bram_en, underflow, cfg_err;
  logic [2:0]  tkeep, tstrb;
  logic [AW-1:0] bram_addr;
  logic [15:0] frame_cnt;
  logic [23:0] pipe [LAT];

  video_img_overlay #(.DATAW(24), .SCRW(16), .SCRH(8), .IMGW(IW), .IMGH(IH), .ADDRW(AW),
                      .BRAM_LAT(LAT), .FIFO_DEPTH(8), .BG_COLOR(BG)) dut (
    .clk(clk), .rstn(rstn), .en(en), .img_x(img_x), .img_y(img_y),
    .subw(subw), .addw(addw), .subh(subh), .addh(addh),
    .m_axis_tdata(tdata), .m_axis_tvalid(tvalid), .m_axis_tready(tready),
    .m_axis_tuser(tuser), .m_axis_tlast(tlast), .m_axis_tkeep(tkeep), .m_axis_tstrb(tstrb),
    .m_axis_tid(tid), .m_axis_tdest(tdest), .bram_en_o(bram_en), .bram_addr_o(bram_addr),
    .bram_data_i(bram_data), .frame_cnt(frame_cnt), .underflow(underflow), .cfg_err(cfg_err));

  always #5 clk = ~clk;

  // BRAM model: word k holds k+1, LAT cycles of read latency
  always @(posedge clk) begin
    pipe[0] <= 24'(bram_addr) + 24'd1;
    for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
  end
  assign bram_data = pipe[LAT-1];

  int checks = 0, fails = 0;
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: actual %0h required %0h", name, act, req);
    end
  endtask

  logic [25:0] exp_q [$];
  int          px_cnt = 0, pulse_cnt = 0;
  logic        stall_prev = 1'b0;
  logic [26:0] stall_word = '0;

  always @(negedge clk) begin
    if (!rstn) stall_prev = 1'b0;
    else begin
      if (stall_prev) check("stall_hold", {tvalid, tdata, tuser, tlast}, stall_word);
      stall_prev = tvalid && !tready;
      stall_word = {tvalid, tdata, tuser, tlast};
      if (bram_en) pulse_cnt++;
      if (tvalid && tready) begin
        px_cnt++;
        if (exp_q.size() == 0) check("extra_pixel", px_cnt, 0);
        else check($sformatf("pixel_%0d", px_cnt), {tdata, tuser, tlast}, exp_q.pop_front());
      end
    end
  end

  bit rnd_mode = 1'b0;
  initial forever begin
    @(posedge clk);
    #1 tready = rnd_mode ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  task automatic push_frame(input int ix, input int iy, input int w, input int h, input bit ok);
    for (int yy = 0; yy < h; yy++)
      for (int xx = 0; xx < w; xx++) begin
        logic [23:0] d;
        bit inw;
        inw = ok && xx >= ix && xx < ix + IW && yy >= iy && yy < iy + IH;
        d = inw ? 24'((yy - iy) * IW + (xx - ix) + 1) : BG;
`ifdef VIDEO_IMG_BORDER_EN
        if (ok && !inw && xx >= ix - 1 && xx <= ix + IW && yy >= iy - 1 && yy <= iy + IH) d = ~BG;
`endif
        exp_q.push_back({d, 1'(xx == 0 && yy == 0), 1'(xx == w - 1)});
      end
  endtask

  task automatic wait_frame(input logic [15:0] fc0);
    int n = 0;
    while (frame_cnt == fc0 && n < 3000) begin @(posedge clk); n++; end
    check("frame_done_timeout", n < 3000, 1);
  endtask

  task automatic wait_px(input int target);
    int n = 0;
    while (px_cnt < target && n < 3000) begin @(posedge clk); n++; end
    check("pixel_wait_timeout", n < 3000, 1);
  endtask

  typedef struct {
    int ix, iy, sw, aw, sh, ah;
    bit rnd;
    int ew, eh;
    bit ecfg;
  } vec_t;

  task automatic run_vec(input vec_t v);
    logic [15:0] fc0;
    int p0, b0, lat;
    img_x = 13'(v.ix); img_y = 13'(v.iy);
    subw = 13'(v.sw); addw = 13'(v.aw); subh = 13'(v.sh); addh = 13'(v.ah);
    rnd_mode = v.rnd;
    push_frame(v.ix, v.iy, v.ew, v.eh, !v.ecfg);
    fc0 = frame_cnt; p0 = px_cnt; b0 = pulse_cnt;
    @(posedge clk);
    #1 en = 1'b1;
    lat = 0;
    do begin
      @(posedge clk);
      lat++;
      if (lat == 1) begin #1 en = 1'b0; end
      @(negedge clk);
    end while (!tvalid && lat < 40);
    check("first_tvalid_latency", lat <= 13, 1);
    wait_frame(fc0);
    repeat (10) @(posedge clk);
    @(negedge clk);
    check("frame_cnt", frame_cnt, 16'(fc0 + 16'd1));
    check("cfg_err", cfg_err, v.ecfg);
    check("underflow", underflow, 0);
    check("pixels_in_frame", px_cnt - p0, v.ew * v.eh);
    check("scoreboard_empty", exp_q.size(), 0);
    check("bram_pulses", pulse_cnt - b0, v.ecfg ? 0 : IW * IH);
    check("idle_tvalid", tvalid, 0);
    rnd_mode = 1'b0;
  endtask

  initial begin
    vec_t vecs [7];
    logic [15:0] fc0;
    int p0, b0;
    vecs[0] = '{5, 2, 0, 0, 0, 0, 1'b0, 16, 8, 1'b0};
    vecs[1] = '{5, 2, 0, 0, 0, 0, 1'b1, 16, 8, 1'b0};
    vecs[2] = '{5, 2, 4, 0, 2, 0, 1'b0, 12, 6, 1'b0};
    vecs[3] = '{14, 2, 0, 0, 0, 0, 1'b0, 16, 8, 1'b1};
    vecs[4] = '{0, 0, 0, 0, 0, 0, 1'b1, 16, 8, 1'b0};
    vecs[5] = '{0, 0, 16, 0, 8, 0, 1'b0, 1, 1, 1'b1};
    vecs[6] = '{14, 5, 0, 2, 0, 0, 1'b1, 18, 8, 1'b0};

    repeat (3) @(posedge clk);
    #1;
    check("rst_tvalid", tvalid, 0);
    check("rst_tuser_tlast", {tuser, tlast}, 0);
    check("rst_tdata", tdata, 0);
    check("rst_frame_cnt", frame_cnt, 0);
    check("rst_flags", {underflow, cfg_err, bram_en}, 0);
    check("rst_keep_strb", {tkeep, tstrb}, 6'h3f);
    check("rst_id_dest", {tid, tdest}, 0);
    rstn = 1'b1;

    foreach (vecs[i]) run_vec(vecs[i]);

    // en dropped mid-frame: the frame still completes, then the block idles
    img_x = 13'd5; img_y = 13'd2; subw = '0; addw = '0; subh = '0; addh = '0;
    push_frame(5, 2, 16, 8, 1'b1);
    fc0 = frame_cnt; p0 = px_cnt; b0 = pulse_cnt;
    @(posedge clk);
    #1 en = 1'b1;
    wait_px(p0 + 40);
    en = 1'b0;
    wait_frame(fc0);
    repeat (20) @(posedge clk);
    @(negedge clk);
    check("drop_en_frame_cnt", frame_cnt, 16'(fc0 + 16'd1));
    check("drop_en_pixels", px_cnt - p0, 128);
    check("drop_en_idle", tvalid, 0);
    check("drop_en_pulses", pulse_cnt - b0, IW * IH);
    check("drop_en_scoreboard", exp_q.size(), 0);

    // async reset in the middle of the next frame, then a clean restart
    push_frame(5, 2, 16, 8, 1'b1);
    p0 = px_cnt;
    @(posedge clk);
    #1 en = 1'b1;
    wait_px(p0 + 60);
    #1 rstn = 1'b0;
    #1;
    check("midrst_tvalid", {tvalid, tuser, tlast}, 0);
    check("midrst_frame_cnt", frame_cnt, 0);
    check("midrst_flags", {underflow, cfg_err, bram_en}, 0);
    exp_q.delete();
    push_frame(5, 2, 16, 8, 1'b1);
    p0 = px_cnt;
    @(posedge clk);
    #1 rstn = 1'b1;
    @(posedge clk);
    #1 en = 1'b0;
    wait_frame(16'd0);
    repeat (10) @(posedge clk);
    @(negedge clk);
    check("restart_frame_cnt", frame_cnt, 1);
    check("restart_pixels", px_cnt - p0, 128);
    check("restart_scoreboard", exp_q.size(), 0);
    check("restart_underflow", underflow, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
